// File: rtl/util_fix_pkg.sv
// rtl/util_fix_pkg.sv - saturation limits and stage record shared by the fixed-point scaler
package util_fix;

  localparam int MAX_W = 32;

  // Wide enough for any legal WIDTH so the limits can be compared after shifting.
  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  typedef struct packed {
    logic [MAX_W-1:0] data;
    logic             last;
    logic             sat;
  } stage_t;

endpackage

// File: rtl/sat_shl_fix.sv
// rtl/sat_shl_fix.sv - combinational signed left shift by SCALE with clip to WIDTH bits
module sat_shl_fix
  import util_fix::*;
#(
  parameter int WIDTH = 8,
  parameter int SCALE = 2
) (
  input  logic signed [WIDTH-1:0] in,
  output logic        [WIDTH-1:0] out,
  output logic                    sat
);

  localparam int IW = WIDTH + SCALE;
  localparam logic signed [IW-1:0] MAX_V = IW'(sat_max(WIDTH));
  localparam logic signed [IW-1:0] MIN_V = IW'(sat_min(WIDTH));

  logic signed [IW-1:0] wide;

  assign wide = IW'(in) <<< SCALE;

  always_comb begin
    out = wide[WIDTH-1:0];
    sat = 1'b0;
    if (wide > MAX_V) begin
      out = MAX_V[WIDTH-1:0];
      sat = 1'b1;
    end else if (wide < MIN_V) begin
      out = MIN_V[WIDTH-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/scaler_mul_fix.sv
// rtl/scaler_mul_fix.sv - 2-stage multiply-by-2^SCALE with saturation; SCALER_MUL_SAT_CNT_EN enables sat_cnt
module scaler_mul_fix #(
  parameter int WIDTH = 8,
  parameter int SCALE = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_sat,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_cnt
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic             s1_last;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic             s2_last;
  logic             s2_sat;
  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] shl_data;
  logic             shl_sat;

  // Each stage moves whenever its downstream slot is empty or draining this cycle.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  sat_shl_fix #(
    .WIDTH(WIDTH),
    .SCALE(SCALE)
  ) u_shl (
    .in (s1_data),
    .out(shl_data),
    .sat(shl_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_last  <= 1'b0;
      s2_sat   <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data <= in_data;
          s1_last <= in_last;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= shl_data;
          s2_last <= s1_last;
          s2_sat  <= shl_sat;
        end
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_last  = s2_last;
  assign out_sat   = s2_sat;

`ifdef SCALER_MUL_SAT_CNT_EN
  logic             out_fire;
  logic [CNT_W-1:0] cnt_q;

  assign out_fire = out_valid && out_ready;

  // Clear takes priority over a coincident counted transfer; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (sat_clr) begin
      cnt_q <= '0;
    end else if (out_fire && s2_sat && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign sat_cnt = cnt_q;
`else
  logic unused_sat_clr;

  assign unused_sat_clr = sat_clr;
  assign sat_cnt        = '0;
`endif

endmodule

// File: tb/tb_scaler_mul_fix.sv
// tb/tb_scaler_mul_fix.sv - directed self-checking bench for scaler_mul_fix (WIDTH=8, SCALE=2)
module tb_scaler_mul_fix;
  import util_fix::*;

`ifdef SCALER_MUL_SAT_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_sat;
  logic        sat_clr;
  logic [15:0] sat_cnt;

  int     n_chk  = 0;
  int     n_fail = 0;
  int     occ    = 0;
  bit     toggle_en = 1'b0;
  stage_t exp_q[$];

  always #5 clk = ~clk;

  scaler_mul_fix #(.WIDTH(8), .SCALE(2), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_sat  (out_sat),
    .sat_clr  (sat_clr),
    .sat_cnt  (sat_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_out(input logic [7:0] d, input logic l, input logic s);
    stage_t e;
    e.data = 32'(d);
    e.last = l;
    e.sat  = s;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l);
    bit acc;
    int t;
    acc = 1'b0;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Scoreboard and in_ready model: the block may only refuse input while both stages are full and stalled.
  always @(negedge clk) begin
    stage_t e;
    if (!rst_n) begin
      occ = 0;
    end else begin
      check("in_ready", 32'(in_ready), (occ == 2 && !out_ready) ? 32'd0 : 32'd1);
      if (in_valid && in_ready) occ++;
      if (out_valid && out_ready) begin
        occ--;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.data[7:0]));
          check("out_last", 32'(out_last), 32'(e.last));
          check("out_sat",  32'(out_sat),  32'(e.sat));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b1; sat_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_sat",   32'(out_sat),   32'd0);
    check("rst_sat_cnt",   32'(sat_cnt),   32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain scaling and two-cycle latency
    expect_out(8'h20, 1'b0, 1'b0);
    expect_out(8'h04, 1'b0, 1'b0);
    expect_out(8'hFC, 1'b0, 1'b0);
    expect_out(8'h7C, 1'b0, 1'b0);
    send(8'h08, 1'b0);
    @(negedge clk);
    check("lat_edge1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_edge2_valid", 32'(out_valid), 32'd1);
    check("lat_edge2_data",  32'(out_data),  32'h20);
    @(posedge clk); #1;
    send(8'h01, 1'b0);
    send(8'hFF, 1'b0);
    send(8'h1F, 1'b0);
    drain("drain_scale");

    // Positive and negative clipping
    expect_out(8'h7F, 1'b0, 1'b1);
    expect_out(8'h80, 1'b0, 1'b1);
    expect_out(8'h80, 1'b0, 1'b1);
    expect_out(8'h00, 1'b0, 1'b0);
    send(8'h20, 1'b0);
    send(8'h88, 1'b0);
    send(8'h81, 1'b0);
    send(8'h00, 1'b0);
    drain("drain_sat");
    @(negedge clk);
    check("sat_cnt_3", 32'(sat_cnt), 32'(3 * CNT_EN));
    @(posedge clk); #1;

    // Back-to-back stream with out_ready toggling 1,0,0,1
    for (int i = 1; i <= 10; i++) expect_out(8'(i * 4), 1'b0, 1'b0);
    toggle_en = 1'b1;
    fork
      begin
        int k;
        k = 0;
        while (toggle_en) begin
          out_ready = (k % 4 == 0) || (k % 4 == 3);
          k++;
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join_none
    for (int i = 1; i <= 10; i++) send(8'(i), 1'b0);
    drain("drain_stream");
    toggle_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Counter to 5, then clear coinciding with a saturated transfer
    expect_out(8'h7F, 1'b0, 1'b1);
    expect_out(8'h80, 1'b0, 1'b1);
    send(8'h40, 1'b0);
    send(8'hC0, 1'b0);
    drain("drain_sat5");
    @(negedge clk);
    check("sat_cnt_5", 32'(sat_cnt), 32'(5 * CNT_EN));
    @(posedge clk); #1;
    expect_out(8'h7F, 1'b0, 1'b1);
    send(8'h7F, 1'b0);
    @(posedge clk); #1;
    sat_clr = 1'b1;
    @(negedge clk);
    check("clr_coincident_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    sat_clr = 1'b0;
    @(negedge clk);
    check("sat_cnt_clr_wins", 32'(sat_cnt), 32'd0);
    @(posedge clk); #1;
    expect_out(8'h80, 1'b0, 1'b1);
    send(8'hA0, 1'b0);
    drain("drain_after_clr");
    @(negedge clk);
    check("sat_cnt_resume", 32'(sat_cnt), 32'(1 * CNT_EN));
    @(posedge clk); #1;

    // Mid-stream reset with both stages full
    out_ready = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_sat_cnt",   32'(sat_cnt),   32'd0);
    check("midrst_out_data",  32'(out_data),  32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    expect_out(8'h08, 1'b0, 1'b0);
    send(8'h02, 1'b0);
    @(negedge clk);
    check("postrst_lat1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("postrst_lat2_valid", 32'(out_valid), 32'd1);
    check("postrst_lat2_data",  32'(out_data),  32'h08);
    @(posedge clk); #1;
    drain("drain_postrst");

    // in_last travels with its sample; full rate with out_ready high
    expect_out(8'h0C, 1'b0, 1'b0);
    expect_out(8'h14, 1'b0, 1'b0);
    expect_out(8'h1C, 1'b0, 1'b0);
    expect_out(8'h24, 1'b1, 1'b0);
    t0 = $time;
    send(8'h03, 1'b0);
    send(8'h05, 1'b0);
    send(8'h07, 1'b0);
    send(8'h09, 1'b1);
    check("throughput_cycles", 32'(($time - t0) / 10), 32'd4);
    drain("drain_last");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
